// File: rtl/switch_pkg.sv
// ============================================================================
// Module   : switch_pkg
// Brief    : Shared types, constants and helpers for master_switch_ctrl.
//            Default cycle counts are derived from MASTER_SWITCH_OSC_HZ.
//            Optional feature macro: MASTER_SWITCH_REVERT_EN (see top level).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef MASTER_SWITCH_OSC_HZ
`define MASTER_SWITCH_OSC_HZ 14745600
`endif

package switch_pkg;

    // Controller states; ACT covers both A-active and B-active (see sel_b)
    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_ACT  = 2'd1,
        ST_HOLD = 2'd2,
        ST_NONE = 2'd3
    } state_t;

    localparam int OSC_HZ             = `MASTER_SWITCH_OSC_HZ;
    localparam int DEF_STARTUP_CYCLES = OSC_HZ / 10;    // 0.1 s
    localparam int DEF_HOLDOFF_CYCLES = OSC_HZ / 100;   // 10 ms
    localparam int DEF_REVERT_CYCLES  = OSC_HZ / 10;    // 0.1 s
    localparam int DEF_CNT_W          = 24;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Saturating 8-bit increment for the switch counter
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_edge_det.sv
// ============================================================================
// Module   : sync_edge_det
// Brief    : 2-FF synchronizer for an asynchronous level followed by a
//            rising-edge detector. The pulse is valid in the cycle after the
//            second synchronizer stage first captures a 1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    // sh[0], sh[1]: synchronizer stages; sh[2]: previous synchronized value
    logic [2:0] sh;

    // Shift the asynchronous level through the synchronizer and history stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh <= 3'b000;
        end else begin
            sh <= {sh[1:0], async_in};
        end
    end

    assign rise = sh[1] & ~sh[2];

endmodule

`default_nettype wire

// File: rtl/master_switch_ctrl.sv
// ============================================================================
// Module   : master_switch_ctrl
// Brief    : Selects which redundant core (A/B) drives the shared bus based on
//            heartbeat status, operator force requests, a startup window and a
//            post-switch holdoff. Optional auto-revert to core A is built when
//            MASTER_SWITCH_REVERT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module master_switch_ctrl
    import switch_pkg::*;
#(
    parameter int STARTUP_CYCLES = DEF_STARTUP_CYCLES,
    parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
    parameter int CNT_W          = DEF_CNT_W,
    parameter int REVERT_CYCLES  = DEF_REVERT_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alive_a,
    input  logic       alive_b,
    input  logic       force_req,
    input  logic       force_sel,
    output logic       sel_b,
    output logic       sel_valid,
    output logic       no_master,
    output logic       switch_pulse,
    output logic       force_rej,
    output logic [7:0] switch_count
);

    localparam logic [CNT_W-1:0] STARTUP_LAST = CNT_W'(STARTUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] timer;
    logic             force_edge;
    logic             cur;
    logic             oth;
    logic             force_diff;
    logic             revert_hit;
    logic             sw_hold;

    sync_edge_det u_force_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (force_req),
        .rise     (force_edge)
    );

    assign cur        = sel_b ? alive_b : alive_a;
    assign oth        = sel_b ? alive_a : alive_b;
    assign force_diff = force_edge & (force_sel != sel_b);

    // Any switch that lands in HOLD: failover, auto-revert or accepted force
    // from ACT (failover wins because ~cur is checked first), or recovery of
    // only the non-selected core from NONE. All require the other core alive.
    assign sw_hold = oth & (((state == ST_ACT)  & (~cur | revert_hit | force_diff)) |
                            ((state == ST_NONE) & ~cur));

`ifdef MASTER_SWITCH_REVERT_EN
    localparam logic [CNT_W-1:0] REVERT_LAST = CNT_W'(REVERT_CYCLES - 1);

    logic [CNT_W-1:0] rev_cnt;
    logic             rev_run;

    assign rev_run    = (state == ST_ACT) & (sel_b == SEL_B) & alive_a;
    assign revert_hit = rev_run & (rev_cnt == REVERT_LAST);

    // Measure continuous core-A health while B is master; restart on any gap or switch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rev_cnt <= '0;
        end else if (rev_run && !sw_hold) begin
            rev_cnt <= rev_cnt + 1'b1;
        end else begin
            rev_cnt <= '0;
        end
    end
`else
    logic unused_revert_cfg;

    assign revert_hit        = 1'b0;
    assign unused_revert_cfg = (REVERT_CYCLES != 0);
`endif

    // Master-selection state machine with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_INIT;
            timer        <= '0;
            sel_b        <= SEL_A;
            sel_valid    <= 1'b0;
            no_master    <= 1'b0;
            switch_pulse <= 1'b0;
            force_rej    <= 1'b0;
            switch_count <= 8'd0;
        end else begin
            switch_pulse <= 1'b0;
            force_rej    <= 1'b0;

            if (sw_hold) begin
                state        <= ST_HOLD;
                timer        <= '0;
                sel_b        <= ~sel_b;
                no_master    <= 1'b0;
                switch_pulse <= 1'b1;
                switch_count <= sat_inc8(switch_count);
                // A force from NONE is still refused even if a recovery switch happens
                force_rej    <= (state == ST_NONE) & force_edge;
            end else begin
                case (state)
                    ST_INIT: begin
                        force_rej <= force_edge;
                        if (timer == STARTUP_LAST) begin
                            timer     <= '0;
                            sel_valid <= 1'b1;
                            if (alive_a) begin
                                state <= ST_ACT;
                                sel_b <= SEL_A;
                            end else if (alive_b) begin
                                state        <= ST_ACT;
                                sel_b        <= SEL_B;
                                switch_pulse <= 1'b1;
                                switch_count <= sat_inc8(switch_count);
                            end else begin
                                state     <= ST_NONE;
                                sel_b     <= SEL_A;
                                no_master <= 1'b1;
                            end
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    ST_ACT: begin
                        timer <= '0;
                        if (!cur) begin
                            // Other core also dead (else sw_hold would be set)
                            state     <= ST_NONE;
                            no_master <= 1'b1;
                        end else if (force_diff) begin
                            // Requested core is not alive
                            force_rej <= 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        force_rej <= force_edge;
                        if (timer == HOLDOFF_LAST) begin
                            state <= ST_ACT;
                            timer <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    default: begin // ST_NONE
                        timer     <= '0;
                        force_rej <= force_edge;
                        if (cur) begin
                            state     <= ST_ACT;
                            no_master <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_master_switch_ctrl.sv
// ============================================================================
// Module   : tb_master_switch_ctrl
// Brief    : Directed self-checking bench for master_switch_ctrl with
//            STARTUP_CYCLES=100, HOLDOFF_CYCLES=50, REVERT_CYCLES=200.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_master_switch_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       alive_a = 1'b0;
    logic       alive_b = 1'b0;
    logic       force_req = 1'b0;
    logic       force_sel = 1'b0;
    logic       sel_b;
    logic       sel_valid;
    logic       no_master;
    logic       switch_pulse;
    logic       force_rej;
    logic [7:0] switch_count;

    int total = 0;
    int bad   = 0;

    master_switch_ctrl #(
        .STARTUP_CYCLES (100),
        .HOLDOFF_CYCLES (50),
        .CNT_W          (24),
        .REVERT_CYCLES  (200)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alive_a      (alive_a),
        .alive_b      (alive_b),
        .force_req    (force_req),
        .force_sel    (force_sel),
        .sel_b        (sel_b),
        .sel_valid    (sel_valid),
        .no_master    (no_master),
        .switch_pulse (switch_pulse),
        .force_rej    (force_rej),
        .switch_count (switch_count)
    );

    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Hold reset for two edges, then release just after a rising edge
    task automatic do_reset(input logic a, input logic b);
        rst_n     = 1'b0;
        alive_a   = a;
        alive_b   = b;
        force_req = 1'b0;
        force_sel = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    initial begin
        logic       exp_sel;
        logic [7:0] exp_cnt;

        #2;
        // ---------------- Reset 1: both alive, A chosen at cycle 100
        do_reset(1'b1, 1'b1);
        chk("rst_sel_b", {7'd0, sel_b}, 8'd0);
        chk("rst_valid", {7'd0, sel_valid}, 8'd0);
        chk("rst_nomaster", {7'd0, no_master}, 8'd0);
        chk("rst_pulse", {7'd0, switch_pulse}, 8'd0);
        chk("rst_rej", {7'd0, force_rej}, 8'd0);
        chk("rst_count", switch_count, 8'd0);

        tick(50);                               // force during INIT
        force_req = 1'b1;
        force_sel = 1'b1;
        tick(2);
        chk("init_rej_early", {7'd0, force_rej}, 8'd0);
        tick(1);                                // cycle 53
        chk("init_rej", {7'd0, force_rej}, 8'd1);
        chk("init_rej_sel", {7'd0, sel_b}, 8'd0);
        tick(1);
        chk("init_rej_1clk", {7'd0, force_rej}, 8'd0);
        force_req = 1'b0;
        tick(45);                               // cycle 99
        chk("valid_at_99", {7'd0, sel_valid}, 8'd0);
        tick(1);                                // cycle 100
        chk("valid_at_100", {7'd0, sel_valid}, 8'd1);
        chk("start_sel_a", {7'd0, sel_b}, 8'd0);
        chk("start_no_pulse", {7'd0, switch_pulse}, 8'd0);
        chk("start_count", switch_count, 8'd0);

        // ---------------- Failover A->B, HOLD ignores alive changes, failback
        alive_a = 1'b0;
        tick(1);
        chk("fo_sel", {7'd0, sel_b}, 8'd1);
        chk("fo_pulse", {7'd0, switch_pulse}, 8'd1);
        chk("fo_count", switch_count, 8'd1);
        tick(1);
        chk("fo_pulse_end", {7'd0, switch_pulse}, 8'd0);
        tick(9);
        alive_a = 1'b1;
        alive_b = 1'b0;
        tick(40);                               // HOLD exit edge
        chk("hold_keeps_b", {7'd0, sel_b}, 8'd1);
        tick(1);
        chk("fb_sel", {7'd0, sel_b}, 8'd0);
        chk("fb_pulse", {7'd0, switch_pulse}, 8'd1);
        chk("fb_count", switch_count, 8'd2);

        // ---------------- No master, then only B recovers
        tick(50);
        alive_a = 1'b0;
        alive_b = 1'b0;
        tick(1);
        chk("nm_set", {7'd0, no_master}, 8'd1);
        chk("nm_sel", {7'd0, sel_b}, 8'd0);
        tick(1);
        chk("nm_stay", {7'd0, no_master}, 8'd1);
        alive_b = 1'b1;
        tick(1);
        chk("nm_rec_sel", {7'd0, sel_b}, 8'd1);
        chk("nm_rec_clr", {7'd0, no_master}, 8'd0);
        chk("nm_rec_count", switch_count, 8'd3);

        // ---------------- Forced switch B->A, force during HOLD rejected
        alive_a = 1'b1;
        tick(50);
        force_req = 1'b1;
        force_sel = 1'b0;
        tick(2);
        chk("frc_wait", {7'd0, sel_b}, 8'd1);
        tick(1);
        chk("frc_sel", {7'd0, sel_b}, 8'd0);
        chk("frc_pulse", {7'd0, switch_pulse}, 8'd1);
        chk("frc_count", switch_count, 8'd4);
        force_req = 1'b0;
        tick(3);
        force_req = 1'b1;
        force_sel = 1'b1;
        tick(2);
        chk("hold_rej_early", {7'd0, force_rej}, 8'd0);
        tick(1);
        chk("hold_rej", {7'd0, force_rej}, 8'd1);
        chk("hold_rej_sel", {7'd0, sel_b}, 8'd0);
        tick(1);
        chk("hold_rej_1clk", {7'd0, force_rej}, 8'd0);
        tick(43);
        force_req = 1'b0;
        tick(3);
        force_req = 1'b1;
        force_sel = 1'b1;
        tick(2);
        chk("frc2_wait", {7'd0, sel_b}, 8'd0);
        tick(1);
        chk("frc2_sel", {7'd0, sel_b}, 8'd1);
        chk("frc2_count", switch_count, 8'd5);
        force_req = 1'b0;

        // ---------------- Force towards dead core rejected, same-core force ignored
        tick(50);
        alive_a = 1'b0;
        tick(3);
        force_req = 1'b1;
        force_sel = 1'b0;
        tick(3);
        chk("dead_rej", {7'd0, force_rej}, 8'd1);
        chk("dead_rej_sel", {7'd0, sel_b}, 8'd1);
        chk("dead_rej_nopulse", {7'd0, switch_pulse}, 8'd0);
        force_req = 1'b0;
        tick(3);
        force_req = 1'b1;
        force_sel = 1'b1;
        tick(3);
        chk("same_norej", {7'd0, force_rej}, 8'd0);
        chk("same_sel", {7'd0, sel_b}, 8'd1);
        chk("same_count", switch_count, 8'd5);
        force_req = 1'b0;

        // ---------------- Asynchronous reset in the middle of HOLD
        alive_a = 1'b1;
        alive_b = 1'b0;
        tick(1);
        chk("pre_rst_count", switch_count, 8'd6);
        tick(5);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_sel", {7'd0, sel_b}, 8'd0);
        chk("arst_valid", {7'd0, sel_valid}, 8'd0);
        chk("arst_count", switch_count, 8'd0);

        // ---------------- Reset 2: only B alive at startup
        do_reset(1'b0, 1'b1);
        tick(100);
        chk("initb_sel", {7'd0, sel_b}, 8'd1);
        chk("initb_pulse", {7'd0, switch_pulse}, 8'd1);
        chk("initb_count", switch_count, 8'd1);
        tick(1);
        chk("initb_pulse_end", {7'd0, switch_pulse}, 8'd0);
`ifdef MASTER_SWITCH_REVERT_EN
        alive_a = 1'b1;
        tick(100);
        alive_a = 1'b0;
        tick(1);
        alive_a = 1'b1;
        tick(199);
        chk("rev_wait", {7'd0, sel_b}, 8'd1);
        tick(1);
        chk("rev_sel", {7'd0, sel_b}, 8'd0);
        chk("rev_pulse", {7'd0, switch_pulse}, 8'd1);
        chk("rev_count", switch_count, 8'd2);
`else
        alive_a = 1'b1;
        tick(300);
        chk("norev_sel", {7'd0, sel_b}, 8'd1);
        chk("norev_count", switch_count, 8'd1);
`endif

        // ---------------- Reset 3: nobody alive at startup
        do_reset(1'b0, 1'b0);
        tick(99);
        chk("none_nm_99", {7'd0, no_master}, 8'd0);
        tick(1);
        chk("none_nm", {7'd0, no_master}, 8'd1);
        chk("none_valid", {7'd0, sel_valid}, 8'd1);
        chk("none_sel", {7'd0, sel_b}, 8'd0);
        chk("none_pulse", {7'd0, switch_pulse}, 8'd0);
        alive_a = 1'b1;
        alive_b = 1'b1;
        tick(1);
        chk("none_both_sel", {7'd0, sel_b}, 8'd0);
        chk("none_both_nm", {7'd0, no_master}, 8'd0);
        chk("none_both_count", switch_count, 8'd0);

        // ---------------- Reset 4: switch counter saturation
        do_reset(1'b1, 1'b1);
        tick(100);
        exp_sel = 1'b0;
        exp_cnt = 8'd0;
        for (int i = 0; i < 260; i++) begin
            alive_a = exp_sel;
            alive_b = ~exp_sel;
            tick(1);
            exp_sel = ~exp_sel;
            exp_cnt = (exp_cnt == 8'd255) ? exp_cnt : exp_cnt + 8'd1;
            if (i == 253 || i == 254 || i == 259) begin
                chk("sat_sel", {7'd0, sel_b}, {7'd0, exp_sel});
                chk("sat_count", switch_count, exp_cnt);
            end
            tick(50);
        end
        chk("sat_final", switch_count, 8'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
